// File: rtl/ddr2_wr_pkg.sv
// ============================================================================
// Package     : ddr2_wr_pkg
// Description : Shared definitions for the DDR2 write-path burst sequencer:
//               FSM state encoding and the burst-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr2_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } wr_state_e;

  // Width able to hold the values 0..burst inclusive.
  function automatic int BURST_CNT_W(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_skid_buf.sv
// ============================================================================
// Module      : wr_skid_buf
// Description : One-entry skid that absorbs the FIFO's one-cycle read
//               latency. A word that arrives while the sink is stalled is
//               parked here and presented first on the next transfer.
// Ports       : clk_i, rst_i        clock, async active-high reset
//               in_data_i, in_vd_i  word arriving from the FIFO
//               out_rdy_i           sink can accept data
//               out_data_o          presented word (0 when nothing valid)
//               out_vd_o            presented word is valid
//               full_o              skid holds a word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_skid_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_vd_i,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_vd_o,
  output logic                  full_o
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (out_rdy_i) full_d = 1'b0;
    end else if (in_vd_i && !out_rdy_i) begin
      // The reader only issues a read while the skid is empty, so an
      // arriving word never collides with a parked one.
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_vd_o   = full_q | in_vd_i;
  assign out_data_o = full_q ? data_q : (in_vd_i ? in_data_i : '0);
  assign full_o     = full_q;

endmodule

`default_nettype wire

// File: rtl/wr_burst_ctrl.sv
// ============================================================================
// Module      : wr_burst_ctrl
// Description : Write-path burst sequencer. Waits until a full burst is
//               buffered in wr_fifo, requests a write command, then moves
//               WRITE_BURST words from the FIFO to the controller with
//               ready/valid backpressure. The address advances per burst and
//               wraps to base_addr at addr_limit.
// Ports       : rd_clk, reset            clock, async active-high reset
//               enable                   allow new bursts
//               base_addr, addr_limit    address region [base, limit)
//               rd_data_count            FIFO fill level
//               fifo_data, fifo_vd       FIFO read data / valid
//               rd_fifo                  FIFO read enable
//               wr_req, wr_addr, wr_ack  command handshake
//               wr_data, wr_data_vd,
//               wr_data_rdy              data handshake
//               burst_done, busy         status
//               burst_cnt                completed-burst count
// Config      : WR_BURST_CNT_EN - when defined, burst_cnt counts completed
//               bursts (wrapping 16-bit); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_burst_ctrl
  import ddr2_wr_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int WRITE_BURST = 8,
  parameter int ADDR_WIDTH  = 27
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] addr_limit,
  input  logic [9:0]            rd_data_count,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_vd,
  output logic                  rd_fifo,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_ack,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_vd,
  input  logic                  wr_data_rdy,
  output logic                  burst_done,
  output logic                  busy,
  output logic [15:0]           burst_cnt
);

  localparam int               CNT_W   = BURST_CNT_W(WRITE_BURST);
  localparam logic [CNT_W-1:0] BURST_N = CNT_W'(WRITE_BURST);

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  idle_seen_q;
  logic                  load_base;
  logic                  start;
  logic                  xfer;
  logic                  skid_full;
  logic                  skid_in_vd;
  logic [ADDR_WIDTH:0]   addr_next;

  // base_addr is only followed once IDLE has lasted a second cycle (or
  // straight out of reset), so back-to-back bursts keep the advanced address.
  assign load_base  = (state_q == ST_IDLE) && idle_seen_q;
  assign start      = enable && (rd_data_count >= 10'(WRITE_BURST));
  // One extra bit so the limit comparison sees the carry.
  assign addr_next  = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(WRITE_BURST);
  // Words still in flight when the FSM left DATA (e.g. across reset) are
  // ignored.
  assign skid_in_vd = fifo_vd && (state_q == ST_DATA);
  assign xfer       = wr_data_vd && wr_data_rdy;

  wr_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i      (rd_clk),
    .rst_i      (reset),
    .in_data_i  (fifo_data),
    .in_vd_i    (skid_in_vd),
    .out_rdy_i  (wr_data_rdy),
    .out_data_o (wr_data),
    .out_vd_o   (wr_data_vd),
    .full_o     (skid_full)
  );

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    addr_d   = addr_q;
    rd_fifo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issued_d = '0;
        sent_d   = '0;
        if (load_base) addr_d = base_addr;
        if (start)     state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wr_ack) state_d = ST_DATA;
      end
      ST_DATA: begin
        rd_fifo = wr_data_rdy && !skid_full && (issued_q < BURST_N);
        if (rd_fifo) issued_d = issued_q + 1'b1;
        if (xfer) begin
          sent_d = sent_q + 1'b1;
          if (sent_d == BURST_N) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        addr_d  = (addr_next >= {1'b0, addr_limit}) ? base_addr
                                                    : addr_next[ADDR_WIDTH-1:0];
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Gives rd_data_count a cycle to reflect the drained burst.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      sent_q      <= '0;
      addr_q      <= '0;
      idle_seen_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      addr_q      <= addr_d;
      idle_seen_q <= (state_q == ST_IDLE);
    end
  end

  assign wr_req     = (state_q == ST_REQ);
  assign burst_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign wr_addr    = load_base ? base_addr : addr_q;

`ifdef WR_BURST_CNT_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else if (state_q == ST_DONE) begin
      burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign burst_cnt = burst_cnt_q;
`else
  assign burst_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_burst_ctrl.sv
// ============================================================================
// Module      : tb_wr_burst_ctrl
// Description : Directed self-checking bench for wr_burst_ctrl with a small
//               FIFO model (one-cycle read latency) and auto-ack responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wr_burst_ctrl;

  localparam int DW = 64;
  localparam int WB = 8;
  localparam int AW = 27;
`ifdef WR_BURST_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [DW-1:0] WORD_BASE = 64'hA5A5_0000_0000_0000;
  localparam logic [DW-1:0] JUNK      = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [AW-1:0] BASE      = 27'h100;
  localparam logic [AW-1:0] LIMIT     = 27'h110;

  logic          rd_clk, reset, enable;
  logic [AW-1:0] base_addr, addr_limit, wr_addr;
  logic [9:0]    rd_data_count;
  logic [DW-1:0] fifo_data, wr_data;
  logic          fifo_vd, rd_fifo, wr_req, wr_ack, wr_data_vd, wr_data_rdy;
  logic          burst_done, busy;
  logic [15:0]   burst_cnt;

  wr_burst_ctrl #(.DATA_WIDTH(DW), .WRITE_BURST(WB), .ADDR_WIDTH(AW)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .base_addr(base_addr),
    .addr_limit(addr_limit), .rd_data_count(rd_data_count),
    .fifo_data(fifo_data), .fifo_vd(fifo_vd), .rd_fifo(rd_fifo),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_data(wr_data),
    .wr_data_vd(wr_data_vd), .wr_data_rdy(wr_data_rdy),
    .burst_done(burst_done), .busy(busy), .burst_cnt(burst_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int vec = 0;
  int err = 0;

  // Observation log filled by tick()
  int            cyc = 0;
  logic [DW-1:0] xfer_q[$];
  int            xfer_cyc[$];
  logic [AW-1:0] req_addr_q[$];
  int            req_cyc_q[$];
  int            done_cnt, done_cyc, rd_cnt, first_rd_cyc, req_len, req_max;
  int            rd_idx = 0;
  int            bursts_since_rst = 0;
  bit            prev_req, prev_done, rd_s, auto_ack, req_seen, busy_seen;
  bit            held_vd, rd_while_stall;
  logic [DW-1:0] held_data;
  logic [AW-1:0] addr_after_done;

  task automatic clear_log();
    xfer_q.delete(); xfer_cyc.delete(); req_addr_q.delete(); req_cyc_q.delete();
    done_cnt = 0; done_cyc = 0; rd_cnt = 0; first_rd_cyc = 0; req_max = 0;
    req_seen = 0; busy_seen = 0; held_vd = 0; held_data = '0; rd_while_stall = 0;
    addr_after_done = '0;
  endtask

  // One clock: observe at negedge, then update FIFO model and ack after posedge.
  task automatic tick();
    @(negedge rd_clk);
    cyc++;
    if (wr_data_vd && wr_data_rdy) begin
      xfer_q.push_back(wr_data);
      xfer_cyc.push_back(cyc);
    end
    if (burst_done) begin
      done_cnt++; done_cyc = cyc; bursts_since_rst++;
    end
    if (prev_done) addr_after_done = wr_addr;
    prev_done = burst_done;
    if (wr_req && !prev_req) begin
      req_addr_q.push_back(wr_addr);
      req_cyc_q.push_back(cyc);
    end
    prev_req = wr_req;
    if (wr_req) req_len++; else req_len = 0;
    if (req_len > req_max) req_max = req_len;
    if (wr_req) req_seen = 1;
    if (busy) busy_seen = 1;
    if (!wr_data_rdy) begin
      held_vd   = wr_data_vd;
      held_data = wr_data;
      if (rd_fifo) rd_while_stall = 1;
    end
    if (rd_fifo && rd_cnt == 0) first_rd_cyc = cyc;
    if (rd_fifo) rd_cnt++;
    rd_s = rd_fifo;
    @(posedge rd_clk);
    #1;
    fifo_vd = rd_s;
    if (rd_s) begin
      fifo_data = WORD_BASE | 64'(rd_idx);
      rd_idx++;
    end else begin
      fifo_data = JUNK;
    end
    wr_ack = auto_ack && (req_len == 1);
  endtask

  task automatic test_reset();
    logic [63:0] obs [8];
    logic [63:0] exp [8];
    reset = 1'b1;
    repeat (2) @(posedge rd_clk);
    #3;
    obs[0] = 64'(rd_fifo);    exp[0] = 64'd0;
    obs[1] = 64'(wr_req);     exp[1] = 64'd0;
    obs[2] = 64'(wr_data_vd); exp[2] = 64'd0;
    obs[3] = 64'(wr_data);    exp[3] = 64'd0;
    obs[4] = 64'(burst_done); exp[4] = 64'd0;
    obs[5] = 64'(busy);       exp[5] = 64'd0;
    obs[6] = 64'(burst_cnt);  exp[6] = 64'd0;
    obs[7] = 64'(wr_addr);    exp[7] = 64'(BASE);
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (obs[i] !== exp[i]) begin
        $display("FAIL reset_out%0d: got %h expected %h", i, obs[i], exp[i]);
        err++;
      end
    end
    @(posedge rd_clk); #1;
    reset = 1'b0;
    bursts_since_rst = 0;
    prev_req = 0; prev_done = 0; req_len = 0;
    repeat (3) tick();
    vec++;
    if (wr_addr !== BASE || busy !== 1'b0) begin
      $display("FAIL reset_release: wr_addr=%h busy=%b expected %h/0", wr_addr, busy, BASE);
      err++;
    end
  endtask

  task automatic test_single_burst();
    int start_idx;
    clear_log();
    start_idx = rd_idx;
    rd_data_count = 10'd8; enable = 1'b1; wr_data_rdy = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      tick();
      if (req_seen) rd_data_count = 10'd0;
    end
    repeat (10) tick();
    vec++;
    if (done_cnt != 1) begin
      $display("FAIL single_done: got %0d bursts expected 1", done_cnt); err++;
    end
    vec++;
    if (req_addr_q.size() != 1 || req_addr_q[0] !== BASE) begin
      $display("FAIL single_req: %0d reqs first %h expected 1 at %h", req_addr_q.size(),
               (req_addr_q.size() > 0) ? req_addr_q[0] : '0, BASE); err++;
    end
    vec++;
    if (req_max != 2) begin
      $display("FAIL single_req_len: got %0d cycles expected 2", req_max); err++;
    end
    vec++;
    if (xfer_q.size() != WB) begin
      $display("FAIL single_xfers: got %0d expected %0d", xfer_q.size(), WB); err++;
    end else begin
      for (int i = 0; i < WB; i++) begin
        vec++;
        if (xfer_q[i] !== (WORD_BASE | 64'(start_idx + i))) begin
          $display("FAIL single_data%0d: got %h expected %h", i, xfer_q[i],
                   WORD_BASE | 64'(start_idx + i)); err++;
        end
      end
      vec++;
      if (first_rd_cyc - req_cyc_q[0] != 2 || xfer_cyc[WB-1] - first_rd_cyc != WB) begin
        $display("FAIL single_timing: rd at +%0d (expected 2), data span %0d (expected %0d)",
                 first_rd_cyc - req_cyc_q[0], xfer_cyc[WB-1] - first_rd_cyc, WB); err++;
      end
      vec++;
      if (done_cyc - xfer_cyc[WB-1] != 1) begin
        $display("FAIL single_done_timing: got %0d expected 1", done_cyc - xfer_cyc[WB-1]); err++;
      end
    end
    vec++;
    if (addr_after_done !== 27'h108) begin
      $display("FAIL single_addr: got %h expected 108", addr_after_done); err++;
    end
    vec++;
    if (burst_cnt !== (CNT_EN ? 16'(bursts_since_rst) : 16'd0)) begin
      $display("FAIL single_cnt: got %0d expected %0d", burst_cnt,
               CNT_EN ? bursts_since_rst : 0); err++;
    end
  endtask

  task automatic test_backpressure();
    int  start_idx, drop_left;
    bit  dropped;
    clear_log();
    start_idx = rd_idx; dropped = 0; drop_left = 0;
    rd_data_count = 10'd8; enable = 1'b1; wr_data_rdy = 1'b1;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      tick();
      if (req_seen) rd_data_count = 10'd0;
      if (rd_cnt == 3 && !dropped) begin
        dropped = 1; drop_left = 3; wr_data_rdy = 1'b0;
      end else if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) wr_data_rdy = 1'b1;
      end
    end
    wr_data_rdy = 1'b1;
    repeat (10) tick();
    vec++;
    if (done_cnt != 1) begin
      $display("FAIL bp_done: got %0d expected 1", done_cnt); err++;
    end
    vec++;
    if (!held_vd || held_data !== (WORD_BASE | 64'(start_idx + 2))) begin
      $display("FAIL bp_skid: vd=%b data=%h expected 1/%h", held_vd, held_data,
               WORD_BASE | 64'(start_idx + 2)); err++;
    end
    vec++;
    if (rd_while_stall) begin
      $display("FAIL bp_rd_stall: rd_fifo=1 expected 0 while stalled"); err++;
    end
    vec++;
    if (xfer_q.size() != WB) begin
      $display("FAIL bp_xfers: got %0d expected %0d", xfer_q.size(), WB); err++;
    end else begin
      for (int i = 0; i < WB; i++) begin
        vec++;
        if (xfer_q[i] !== (WORD_BASE | 64'(start_idx + i))) begin
          $display("FAIL bp_data%0d: got %h expected %h", i, xfer_q[i],
                   WORD_BASE | 64'(start_idx + i)); err++;
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 27'h100; exp_a[1] = 27'h108; exp_a[2] = 27'h100;
    clear_log();
    rd_data_count = 10'd8; enable = 1'b1; wr_data_rdy = 1'b1;
    for (int i = 0; i < 300 && done_cnt < 3; i++) begin
      tick();
      if (req_addr_q.size() >= 3) rd_data_count = 10'd0;
    end
    repeat (10) tick();
    vec++;
    if (req_addr_q.size() != 3 || done_cnt != 3) begin
      $display("FAIL wrap_count: got %0d reqs %0d bursts expected 3/3", req_addr_q.size(), done_cnt);
      err++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (req_addr_q[i] !== exp_a[i]) begin
          $display("FAIL wrap_addr%0d: got %h expected %h", i, req_addr_q[i], exp_a[i]); err++;
        end
      end
      vec++;
      if (xfer_q.size() != 3 * WB || req_cyc_q[1] - xfer_cyc[WB-1] != 4) begin
        $display("FAIL wrap_gap: xfers=%0d gap=%0d expected %0d/4", xfer_q.size(),
                 (xfer_q.size() >= WB) ? req_cyc_q[1] - xfer_cyc[WB-1] : -1, 3 * WB); err++;
      end
    end
    vec++;
    if (burst_cnt !== (CNT_EN ? 16'(bursts_since_rst) : 16'd0)) begin
      $display("FAIL wrap_cnt: got %0d expected %0d", burst_cnt, CNT_EN ? bursts_since_rst : 0);
      err++;
    end
  endtask

  task automatic test_insufficient();
    clear_log();
    rd_data_count = 10'd7; enable = 1'b1;
    repeat (50) tick();
    vec++;
    if (req_seen) begin
      $display("FAIL short_req: wr_req=1 expected 0"); err++;
    end
    vec++;
    if (busy_seen) begin
      $display("FAIL short_busy: busy=1 expected 0"); err++;
    end
    rd_data_count = 10'd0;
  endtask

  task automatic test_disable_mid();
    int start_idx;
    clear_log();
    start_idx = rd_idx;
    rd_data_count = 10'd16; enable = 1'b1; wr_data_rdy = 1'b1;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      tick();
      if (xfer_q.size() >= 4) enable = 1'b0;
    end
    repeat (20) tick();
    vec++;
    if (done_cnt != 1 || req_addr_q.size() != 1 || xfer_q.size() != WB) begin
      $display("FAIL dis_counts: bursts=%0d reqs=%0d xfers=%0d expected 1/1/%0d",
               done_cnt, req_addr_q.size(), xfer_q.size(), WB); err++;
    end else begin
      vec++;
      if (xfer_q[WB-1] !== (WORD_BASE | 64'(start_idx + WB - 1))) begin
        $display("FAIL dis_last: got %h expected %h", xfer_q[WB-1],
                 WORD_BASE | 64'(start_idx + WB - 1)); err++;
      end
    end
    rd_data_count = 10'd0;
  endtask

  task automatic test_reset_mid();
    bit busy_pre;
    clear_log();
    rd_data_count = 10'd8; enable = 1'b1; wr_data_rdy = 1'b1;
    for (int i = 0; i < 100 && xfer_q.size() < 2; i++) tick();
    vec++;
    if (xfer_q.size() < 2) begin
      $display("FAIL rmid_timeout: got %0d xfers expected 2", xfer_q.size()); err++;
    end
    #2;
    busy_pre = busy;
    reset = 1'b1;
    bursts_since_rst = 0;
    #1;
    vec++;
    if (busy_pre !== 1'b1) begin
      $display("FAIL rmid_pre_busy: got %b expected 1", busy_pre); err++;
    end
    vec++;
    if ({busy, wr_req, rd_fifo, wr_data_vd, burst_done} !== 5'b0) begin
      $display("FAIL rmid_ctrl: busy/req/rd/vd/done=%b expected 00000",
               {busy, wr_req, rd_fifo, wr_data_vd, burst_done}); err++;
    end
    vec++;
    if (wr_data !== '0 || burst_cnt !== 16'd0 || wr_addr !== BASE) begin
      $display("FAIL rmid_data: wr_data=%h cnt=%0d addr=%h expected 0/0/%h",
               wr_data, burst_cnt, wr_addr, BASE); err++;
    end
    rd_data_count = 10'd0; fifo_vd = 1'b0; fifo_data = JUNK; wr_ack = 1'b0;
    @(posedge rd_clk); #1;
    reset = 1'b0;
    prev_req = 0; prev_done = 0; req_len = 0;
    repeat (5) tick();
    vec++;
    if (busy !== 1'b0 || wr_req !== 1'b0) begin
      $display("FAIL rmid_after: busy=%b wr_req=%b expected 0/0", busy, wr_req); err++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; base_addr = BASE; addr_limit = LIMIT;
    rd_data_count = 10'd0; fifo_data = JUNK; fifo_vd = 1'b0; wr_ack = 1'b0;
    wr_data_rdy = 1'b1; auto_ack = 1'b1; req_len = 0;
    clear_log();
    test_reset();
    test_single_burst();
    test_backpressure();
    test_addr_wrap();
    test_insufficient();
    test_disable_mid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wr_burst_ctrl.md
# wr_burst_ctrl

Write-path burst sequencer that drains `wr_fifo` on its read side and feeds the DDR2 controller's write port. When at least one full burst is buffered, it requests a write command at the current address, then reads exactly `WRITE_BURST` words from the FIFO and forwards them with ready/valid backpressure. A one-entry skid absorbs the FIFO's one-cycle read latency. After each burst the address advances, wrapping inside a programmable region.

## Interface
- `DATA_WIDTH`, 64, width of FIFO and controller data words.
- `WRITE_BURST`, 8, words per burst; power of two, 2..256.
- `ADDR_WIDTH`, 27, word-address width.

- `rd_clk`  in  1  sole clock; same as the FIFO read clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows new bursts to start.
- `base_addr`  in  ADDR_WIDTH  region start; sampled in IDLE.
- `addr_limit`  in  ADDR_WIDTH  region end, exclusive.
- `rd_data_count`  in  10  FIFO read-side fill level.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`.
- `fifo_vd`  in  1  FIFO `dout_vd`; valid one cycle after `rd_fifo`.
- `rd_fifo`  out  1  FIFO read enable.
- `wr_req`  out  1  write command request.
- `wr_addr`  out  ADDR_WIDTH  command address; stable while `wr_req` is high.
- `wr_ack`  in  1  controller accepts the command.
- `wr_data`  out  DATA_WIDTH  write data.
- `wr_data_vd`  out  1  `wr_data` is valid.
- `wr_data_rdy`  in  1  controller can accept data.
- `burst_done`  out  1  one-cycle pulse per completed burst.
- `busy`  out  1  high in any state other than IDLE.
- `burst_cnt`  out  16  completed-burst count; see Configuration.

## Operation
- States: IDLE, REQ, DATA, DONE, HOLD.
- IDLE to REQ: `enable` is high and `rd_data_count` is at least `WRITE_BURST`.
- REQ: `wr_req` is high. It drops on the cycle after `wr_ack` is sampled high; the state then goes to DATA.
- DATA: `rd_fifo` = `wr_data_rdy` and not `skid_full` and `issued` < `WRITE_BURST`.
  - `issued` counts FIFO reads; `sent` counts transfers.
  - A transfer occurs on each cycle where `wr_data_vd` and `wr_data_rdy` are both high.
  - When `sent` reaches `WRITE_BURST`, the state goes to DONE.
- Skid path:
  - `wr_data` = skid register if `skid_full`, else `fifo_data`.
  - `wr_data_vd` = `skid_full` or `fifo_vd`.
  - A word arriving with `fifo_vd` high and `wr_data_rdy` low is captured into the skid.
  - The skid drains on the next transfer.
  - A skid overflow is impossible by construction.
- DONE: pulses `burst_done`. `wr_addr` advances by `WRITE_BURST`; if the result is at least `addr_limit`, it reloads `base_addr`. The state then goes to HOLD.
- HOLD: one cycle, to let `rd_data_count` settle; then go to IDLE.
- `enable` low mid-burst: the current burst completes, and no new burst starts.
- `base_addr` change: it loads `wr_addr` only in IDLE while `busy` has been low for 2 or more cycles, or out of reset. It never changes `wr_addr` mid-burst.
- Reset mid-operation: all state returns to IDLE immediately. Any FIFO word in flight is discarded. Upstream must reset the FIFO together with this block.
- Counters are sized clog2(`WRITE_BURST`+1) bits wide. `wr_addr` arithmetic is ADDR_WIDTH+1 bits wide, so the limit comparison sees the carry.

## Timing
- Reset values:
  - `rd_fifo`, `wr_req`, `wr_data_vd`, `burst_done`, `busy` = 0.
  - `wr_data` = 0.
  - `wr_addr` = `base_addr` as sampled on reset release.
  - `burst_cnt` = 0.
  - State = IDLE; skid empty.
- Start condition true at cycle n: `wr_req` is high at n+1.
- `wr_ack` is high at cycle m: `wr_req` is low at m+1, and `rd_fifo` may be high at m+1.
- `rd_fifo` at cycle k: `fifo_vd` and its data appear at k+1.
- With `wr_data_rdy` constantly high, DATA lasts `WRITE_BURST`+1 cycles.
- `burst_done` is high on the cycle after the final transfer.
- Minimum gap between bursts: 3 cycles from the last transfer (DONE, HOLD, IDLE) to the next `wr_req`.
- `wr_ack` has no effect while `wr_req` is low.

## Configuration
- `WR_BURST_CNT_EN` defined: `burst_cnt` increments in DONE, wraps at 16'hFFFF, and is cleared by `reset`.
- `WR_BURST_CNT_EN` undefined: `burst_cnt` is tied to 0 and no counter logic is synthesized.

## Structure
- Package `ddr2_wr_pkg` holds:
  - the state encoding (IDLE=0, REQ=1, DATA=2, DONE=3, HOLD=4, 3 bits);
  - the `BURST_CNT_W` function or constant.
- Sub-module `wr_skid_buf` holds the one-entry skid: data register, `full` flag, output mux.
- FSM, counters and address logic stay in `wr_burst_ctrl`.

## Test plan
- Single burst:
  - Stimulus: count=8, `enable`=1, `base_addr`=0x100, `wr_ack` at the 2nd `wr_req` cycle, `wr_data_rdy`=1.
  - Response: 8 transfers in order, `burst_done` once, `wr_addr` becomes 0x108.
- Backpressure:
  - Stimulus: drop `wr_data_rdy` for 3 cycles right after the 3rd read.
  - Response: the in-flight word is held in the skid, no word is lost or duplicated, and exactly 8 transfers occur.
- Address wrap:
  - Stimulus: `base_addr`=0x100, `addr_limit`=0x110, three bursts.
  - Response: addresses 0x100, 0x108, 0x100.
- Insufficient data:
  - Stimulus: count=7 held for 50 cycles.
  - Response: `wr_req` stays low and `busy`=0.
- Disable mid-burst:
  - Stimulus: `enable`=0 after the 4th transfer, with count=16.
  - Response: the burst finishes with 8 transfers, then no further `wr_req`.
- Reset mid-burst:
  - Stimulus: assert `reset` during DATA.
  - Response: all outputs return to their reset values asynchronously, and with `WR_BURST_CNT_EN` defined, `burst_cnt`=0.
